fetch_ctrl: RTL and testbench

Dual-issue fetch sequencer that owns the PC and drives the word address of the 2-wide instruction ROM (1024 x 32, registered read, returns words addr and addr+1 one clock after the address is presented). It tracks the single in-flight ROM read and buffers returned instruction pairs in a small FIFO. Pairs are handed to decode over a valid/ready handshake. It also accepts PC redirects from branch/JAL resolution and squashes stale fetches.

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: owns the PC, drives the 2-wide ROM address, tracks the
// single in-flight read and buffers returned instruction pairs for decode.
module fetch_ctrl #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_instr1,
  input  logic [31:0] rom_instr2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr1,
  output logic [31:0] out_instr2,
  output logic        out_valid2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc;
  logic [31:0]   next_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occupancy;
  logic [AW+1:0] demand;
  logic          pop;
  logic          push;
  logic          issue;
  logic          cap_valid2;
  logic [AW-1:0] head;

  logic [31:0] buf_pc     [DEPTH];
  logic [31:0] buf_instr1 [DEPTH];
  logic [31:0] buf_instr2 [DEPTH];
  logic        buf_valid2 [DEPTH];

  assign rom_addr  = pc[11:2];
  assign occupancy = wr_ptr - rd_ptr;
  assign head      = rd_ptr[AW-1:0];

  // Handshake: a pair transfers to decode on any cycle where out_valid && out_ready;
  // while out_valid is high and out_ready low, every out_* signal holds its value.
  assign pop  = out_valid & out_ready;
  assign push = inflight & ~redirect_valid;

  // Slots already committed (buffered plus in flight) after this cycle's pop.
  assign demand = {1'b0, occupancy} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
  assign issue  = ~redirect_valid & (demand < (AW+2)'(DEPTH));

  assign cap_valid2 = (inflight_pc[11:2] != 10'd1023);

  // The last ROM word has no partner, so the sequence wraps back to the ROM base.
  always_comb begin
    next_pc = '0;
    if (pc[11:2] != 10'd1023) begin
      next_pc = {20'd0, pc[11:0] + 12'd8};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC & ~32'd3;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'd3;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= next_pc;
      end
    end
  end

  // A redirect flushes the buffer; any pop that lands on the same edge is dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr[AW-1:0]]     <= inflight_pc;
      buf_instr1[wr_ptr[AW-1:0]] <= rom_instr1;
      buf_instr2[wr_ptr[AW-1:0]] <= cap_valid2 ? rom_instr2 : NOP;
      buf_valid2[wr_ptr[AW-1:0]] <= cap_valid2;
    end
  end

  // Empty buffer presents the reset-time filler rather than stale storage.
  always_comb begin
    out_valid  = 1'b0;
    out_pc     = '0;
    out_instr1 = NOP;
    out_instr2 = NOP;
    out_valid2 = 1'b0;
    if (occupancy != '0) begin
      out_valid  = 1'b1;
      out_pc     = buf_pc[head];
      out_instr1 = buf_instr1[head];
      out_instr2 = buf_instr2[head];
      out_valid2 = buf_valid2[head];
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl against a registered 2-wide ROM stub whose word i
// holds 32'hA000_0000 + i.
module tb_fetch_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BASE  = 32'hA000_0000;

  logic        clk;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr1;
  logic [31:0] rom_instr2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr1;
  logic [31:0] out_instr2;
  logic        out_valid2;

  int checks;
  int failures;

  fetch_ctrl #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_instr1     (rom_instr1),
    .rom_instr2     (rom_instr2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr1     (out_instr1),
    .out_instr2     (out_instr2),
    .out_valid2     (out_valid2)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ROM stub, 1-cycle registered read; the second word index wraps in 10 bits
  always @(posedge clk) begin
    rom_instr1 <= BASE + {22'd0, rom_addr};
    rom_instr2 <= BASE + {22'd0, rom_addr + 10'd1};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".valid"},  {31'd0, out_valid},  32'd0);
    check({tag, ".pc"},     out_pc,              32'd0);
    check({tag, ".instr1"}, out_instr1,          NOP);
    check({tag, ".instr2"}, out_instr2,          NOP);
    check({tag, ".valid2"}, {31'd0, out_valid2}, 32'd0);
  endtask

  // Expected head pair for byte PC pc, derived from the ROM stub contents
  task automatic expect_head(input string tag, input logic [31:0] pc);
    logic [9:0]  word;
    logic        last;
    word = pc[11:2];
    last = (word == 10'd1023);
    check({tag, ".valid"},  {31'd0, out_valid},  32'd1);
    check({tag, ".pc"},     out_pc,              pc);
    check({tag, ".instr1"}, out_instr1,          BASE + {22'd0, word});
    check({tag, ".instr2"}, out_instr2,          last ? NOP : BASE + {22'd0, word} + 32'd1);
    check({tag, ".valid2"}, {31'd0, out_valid2}, last ? 32'd0 : 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    repeat (2) step();
    expect_empty("reset");
    check("reset.rom_addr", {22'd0, rom_addr}, 32'd0);

    // Release and stream with decode always ready
    rst = 1'b0;
    step(); expect_empty("lat1");
    step(); expect_head("first", 32'h0);
    step(); expect_head("second", 32'h8);
    step(); expect_head("third", 32'h10);

    // Backpressure: head stays at 0x10, fetch stops once the buffer fills
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_head("hold", 32'h10);
      if (i >= 2) check("hold.rom_addr", {22'd0, rom_addr}, 32'd12);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_head("drain", 32'h10 + 32'(8 * k));
    end

    // Redirect with a read in flight and pairs buffered, pop on the same edge
    redirect(32'h106);
    expect_empty("redir.r0");
    check("redir.rom_addr", {22'd0, rom_addr}, 32'h41);
    step(); expect_empty("redir.r1");
    step(); expect_head("redir.p0", 32'h104);
    step(); expect_head("redir.p1", 32'h10C);

    // End of ROM: word 1023 pair has no second instruction, then wrap to 0
    redirect(32'hFF4);
    expect_empty("wrap.r0");
    step(); expect_empty("wrap.r1");
    step(); expect_head("wrap.p0", 32'hFF4);
    step(); expect_head("wrap.p1", 32'hFFC);
    step(); expect_head("wrap.p2", 32'h0);

    redirect(32'hFF8);
    expect_empty("top.r0");
    step(); expect_empty("top.r1");
    step(); expect_head("top.p0", 32'hFF8);
    step(); expect_head("top.p1", 32'h0);

    // Back-to-back redirects: only the second target streams
    redirect(32'h40);
    expect_empty("b2b.r0");
    check("b2b.rom_addr0", {22'd0, rom_addr}, 32'h10);
    redirect(32'h80);
    expect_empty("b2b.r1");
    check("b2b.rom_addr1", {22'd0, rom_addr}, 32'h20);
    step(); expect_empty("b2b.r2");
    step(); expect_head("b2b.p0", 32'h80);
    step(); expect_head("b2b.p1", 32'h88);

    // Fill the buffer, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    repeat (4) step();
    expect_head("full", 32'h88);
    #2;
    rst = 1'b1;
    #1;
    expect_empty("async_rst");
    check("async_rst.rom_addr", {22'd0, rom_addr}, 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    step(); expect_empty("restart.r0");
    step(); expect_head("restart.p0", 32'h0);
    step(); expect_head("restart.p1", 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
